// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
// Forwarding selects and stage indices.
package hazard_pkg;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    ALU_EXE  = 2'd1,
    ALU_MEM  = 2'd2,
    MEM_DATA = 2'd3
  } fwd_sel_t;

  localparam int IF   = 0;
  localparam int ID   = 1;
  localparam int EXE  = 2;
  localparam int MEM  = 3;
  localparam int WB   = 4;
  localparam int NSTG = 5;

endpackage

// File: rtl/hazard_ctrl_step_sync.sv
// Debug step button synchroniser.
// Two metastability flops plus an edge flop give a one-cycle pulse.
module step_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic pulse_o
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic edge_q, edge_d;

  always_comb begin
    s1_d   = async_i;
    s2_d   = s1_q;
    edge_d = s2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      edge_q <= edge_d;
    end
  end

  assign pulse_o = s2_q & ~edge_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, interlocks,
// freezes, flushes, debug stepping and a stall counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int RA_W     = 5,
  parameter int MD_LAT   = 4,
  parameter int BR_FLUSH = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RA_W-1:0]  id_rs_addr,
  input  logic [RA_W-1:0]  id_rt_addr,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             id_is_store,
  input  logic             id_md_start,
  input  logic             id_md_read,
  input  logic [RA_W-1:0]  exe_wa,
  input  logic [RA_W-1:0]  mem_wa,
  input  logic             exe_wen,
  input  logic             mem_wen,
  input  logic             exe_is_load,
  input  logic             mem_is_load,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             branch_taken,
  input  logic             debug_en,
  input  logic             debug_step,
  input  logic             perf_clr,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             fwd_m,
  output logic [NSTG-1:0]  stage_en,
  output logic [NSTG-1:0]  stage_rst,
  output logic             md_busy,
  output logic             stall_load,
  output logic             stall_md,
  output logic             stall_mem,
  output logic [CNT_W-1:0] perf_stall_cnt
);

  logic [7:0]       md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] perf_q, perf_d;
  logic             step_pulse;
  logic             dbg_hold;
  logic             id_go;
  logic             rs_ok, rt_ok;
  logic             ex_a, ex_b, me_a, me_b;
  fwd_sel_t         fa, fb;

  step_sync u_step (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (debug_step),
    .pulse_o (step_pulse)
  );

  assign rs_ok = id_rs_used && (id_rs_addr != '0);
  assign rt_ok = id_rt_used && (id_rt_addr != '0);
  assign ex_a  = rs_ok && exe_wen && (exe_wa == id_rs_addr);
  assign ex_b  = rt_ok && exe_wen && (exe_wa == id_rt_addr);
  assign me_a  = rs_ok && mem_wen && (mem_wa == id_rs_addr);
  assign me_b  = rt_ok && mem_wen && (mem_wa == id_rt_addr);

  // An EXE hit shadows MEM even when it is a load that must stall.
  always_comb begin
    fa = NONE;
    fb = NONE;
    if (ex_a)      fa = exe_is_load ? NONE : ALU_EXE;
    else if (me_a) fa = mem_is_load ? MEM_DATA : ALU_MEM;
    if (ex_b)      fb = exe_is_load ? NONE : ALU_EXE;
    else if (me_b) fb = mem_is_load ? MEM_DATA : ALU_MEM;
  end

  assign fwd_a = fa;
  assign fwd_b = fb;
  assign fwd_m = ex_b && exe_is_load && id_is_store;

  assign md_busy    = (md_cnt_q != '0);
  assign stall_load = exe_is_load
                    && (ex_a || (ex_b && !id_is_store));
  assign stall_md   = md_busy && (id_md_start || id_md_read);
  assign stall_mem  = mem_req && !mem_ready;
  assign dbg_hold   = debug_en && !step_pulse;

  always_comb begin
    stage_en  = '1;
    stage_rst = '0;
    id_go     = 1'b0;
    if (!rst_n) begin
      stage_rst = '1;
    end else if (dbg_hold) begin
      stage_en = '0;
    end else if (stall_mem) begin
      stage_en      = '0;
      stage_en[WB]  = 1'b1;
      stage_rst[WB] = 1'b1;
    end else if (stall_load || stall_md) begin
      stage_en[IF]   = 1'b0;
      stage_en[ID]   = 1'b0;
      stage_rst[EXE] = 1'b1;
    end else begin
      id_go = 1'b1;
      if (branch_taken && (BR_FLUSH != 0))
        stage_rst[ID] = 1'b1;
    end
  end

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (id_go && id_md_start)
      md_cnt_d = 8'(MD_LAT);
    else if (md_busy && !dbg_hold)
      md_cnt_d = md_cnt_q - 8'd1;
  end

  always_comb begin
    perf_d = perf_q;
    if (perf_clr)
      perf_d = '0;
    else if ((stall_load || stall_md || stall_mem)
             && !dbg_hold && (perf_q != '1))
      perf_d = perf_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt_q <= '0;
      perf_q   <= '0;
    end else begin
      md_cnt_q <= md_cnt_d;
      perf_q   <= perf_d;
    end
  end

  assign perf_stall_cnt = perf_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed checks of hazard_ctrl
// against a behavioural reference model.
module tb_hazard_ctrl;

  localparam int LAT  = 4;
  localparam int CW   = 4;
  localparam int PMAX = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs_addr, id_rt_addr, exe_wa, mem_wa;
  logic       id_rs_used, id_rt_used, id_is_store;
  logic       id_md_start, id_md_read;
  logic       exe_wen, mem_wen, exe_is_load, mem_is_load;
  logic       mem_req, mem_ready, branch_taken;
  logic       debug_en, debug_step, perf_clr;
  logic [1:0] fwd_a, fwd_b;
  logic       fwd_m, md_busy;
  logic [4:0] stage_en, stage_rst;
  logic       stall_load, stall_md, stall_mem;
  logic [CW-1:0] perf_stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  int cyc, md_done, perf_m, opens;
  logic ea, eb, ma, mb, e_sld, e_smd, e_smem;
  logic e_hold, e_busy, e_go;
  logic [1:0] e_fa, e_fb;
  logic [4:0] e_en, e_rst;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .RA_W(5), .MD_LAT(LAT), .BR_FLUSH(1), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_is_store(id_is_store),
    .id_md_start(id_md_start), .id_md_read(id_md_read),
    .exe_wa(exe_wa), .mem_wa(mem_wa),
    .exe_wen(exe_wen), .mem_wen(mem_wen),
    .exe_is_load(exe_is_load), .mem_is_load(mem_is_load),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .branch_taken(branch_taken),
    .debug_en(debug_en), .debug_step(debug_step),
    .perf_clr(perf_clr),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_m(fwd_m),
    .stage_en(stage_en), .stage_rst(stage_rst),
    .md_busy(md_busy),
    .stall_load(stall_load), .stall_md(stall_md),
    .stall_mem(stall_mem),
    .perf_stall_cnt(perf_stall_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_rs_addr = '0; id_rt_addr = '0;
    id_rs_used = 0;  id_rt_used = 0;
    id_is_store = 0; id_md_start = 0; id_md_read = 0;
    exe_wa = '0; mem_wa = '0;
    exe_wen = 0; mem_wen = 0;
    exe_is_load = 0; mem_is_load = 0;
    mem_req = 0; mem_ready = 0; branch_taken = 0;
    debug_en = 0; debug_step = 0; perf_clr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] sel(logic e, logic m,
                                     logic eld, logic mld);
    if (e) return eld ? 2'd0 : 2'd1;
    if (m) return mld ? 2'd3 : 2'd2;
    return 2'd0;
  endfunction

  initial begin
    idle();
    rst_n = 0;
    #2;
    chk("rst_en", stage_en, 5'b11111);
    chk("rst_rst", stage_rst, 5'b11111);
    chk("rst_busy", md_busy, 0);
    chk("rst_perf", perf_stall_cnt, 0);
    repeat (2) @(posedge clk);
    #4 rst_n = 1;
    tick();

    // Random phase: md scoreboard modelled as a completion time.
    cyc = 0; md_done = 0; perf_m = 0;
    for (int i = 0; i < 500; i++) begin
      id_rs_addr   = 5'($urandom_range(0, 3));
      id_rt_addr   = 5'($urandom_range(0, 3));
      exe_wa       = 5'($urandom_range(0, 3));
      mem_wa       = 5'($urandom_range(0, 3));
      id_rs_used   = 1'($urandom);
      id_rt_used   = 1'($urandom);
      id_is_store  = 1'($urandom);
      exe_wen      = 1'($urandom);
      mem_wen      = 1'($urandom);
      exe_is_load  = ($urandom_range(0, 2) == 0);
      mem_is_load  = 1'($urandom);
      id_md_start  = ($urandom_range(0, 4) == 0);
      id_md_read   = ($urandom_range(0, 4) == 0);
      mem_req      = ($urandom_range(0, 2) == 0);
      mem_ready    = 1'($urandom);
      branch_taken = 1'($urandom);
      debug_en     = ($urandom_range(0, 7) == 0);
      perf_clr     = ($urandom_range(0, 11) == 0);
      #1;
      ea = id_rs_used && id_rs_addr != 0
         && exe_wen && exe_wa == id_rs_addr;
      eb = id_rt_used && id_rt_addr != 0
         && exe_wen && exe_wa == id_rt_addr;
      ma = id_rs_used && id_rs_addr != 0
         && mem_wen && mem_wa == id_rs_addr;
      mb = id_rt_used && id_rt_addr != 0
         && mem_wen && mem_wa == id_rt_addr;
      e_busy = (cyc < md_done);
      e_sld  = exe_is_load && (ea || (eb && !id_is_store));
      e_smd  = e_busy && (id_md_start || id_md_read);
      e_smem = mem_req && !mem_ready;
      e_hold = debug_en;
      e_fa   = sel(ea, ma, exe_is_load, mem_is_load);
      e_fb   = sel(eb, mb, exe_is_load, mem_is_load);
      e_go   = 0;
      if (e_hold) begin
        e_en = 5'b00000; e_rst = 5'b00000;
      end else if (e_smem) begin
        e_en = 5'b10000; e_rst = 5'b10000;
      end else if (e_sld || e_smd) begin
        e_en = 5'b11100; e_rst = 5'b00100;
      end else begin
        e_go = 1;
        e_en = 5'b11111;
        e_rst = branch_taken ? 5'b00010 : 5'b00000;
      end
      if (!(ea && exe_is_load)) chk("r_fwd_a", fwd_a, e_fa);
      if (!(eb && exe_is_load)) chk("r_fwd_b", fwd_b, e_fb);
      chk("r_fwd_m", fwd_m, eb && exe_is_load && id_is_store);
      chk("r_sld", stall_load, e_sld);
      chk("r_smd", stall_md, e_smd);
      chk("r_smem", stall_mem, e_smem);
      chk("r_busy", md_busy, e_busy);
      chk("r_en", stage_en, e_en);
      chk("r_rst", stage_rst, e_rst);
      chk("r_perf", perf_stall_cnt, perf_m);
      if (e_go && id_md_start) md_done = cyc + 1 + LAT;
      else if (e_hold && e_busy) md_done++;
      if (perf_clr) perf_m = 0;
      else if ((e_sld || e_smd || e_smem) && !e_hold)
        perf_m = (perf_m < PMAX) ? perf_m + 1 : PMAX;
      tick();
      cyc++;
    end

    idle();
    repeat (8) tick();

    exe_wa = 3; exe_wen = 1; id_rs_addr = 3; id_rs_used = 1;
    #1;
    chk("exe_fwd_a", fwd_a, 1);
    chk("exe_fwd_nostall", stall_load, 0);
    exe_wa = 0; id_rs_addr = 0;
    #1;
    chk("r0_fwd_a", fwd_a, 0);

    idle();
    exe_wa = 5; exe_wen = 1; exe_is_load = 1;
    id_rt_addr = 5; id_rt_used = 1;
    #1;
    chk("lu_stall", stall_load, 1);
    chk("lu_en", stage_en, 5'b11100);
    chk("lu_rst", stage_rst, 5'b00100);
    id_is_store = 1;
    #1;
    chk("st_fwd_m", fwd_m, 1);
    chk("st_nostall", stall_load, 0);
    chk("st_en", stage_en, 5'b11111);

    idle();
    perf_clr = 1;
    tick();
    perf_clr = 0;
    id_md_start = 1;
    #1;
    chk("md_issue_ok", stall_md, 0);
    tick();
    id_md_start = 0; id_md_read = 1;
    for (int k = 1; k <= 5; k++) begin
      #1;
      chk("md_stall", stall_md, k <= 4);
      if (k == 5) chk("md_perf", perf_stall_cnt, 4);
      tick();
    end

    idle();
    mem_req = 1; branch_taken = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("mw_en", stage_en, 5'b10000);
      chk("mw_rst", stage_rst, 5'b10000);
      tick();
    end
    mem_ready = 1;
    #1;
    chk("mw_br_en", stage_en, 5'b11111);
    chk("mw_br_rst", stage_rst, 5'b00010);

    idle();
    tick();
    debug_en = 1;
    #1;
    chk("dbg_hold", stage_en, 5'b00000);
    debug_step = 1;
    opens = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      #1;
      if (stage_en == 5'b11111) opens++;
      chk("dbg_step_en", stage_en, (k == 2) ? 5'b11111 : 5'b00000);
    end
    chk("dbg_one_step", opens, 1);
    idle();
    repeat (4) tick();

    id_md_start = 1;
    tick();
    id_md_start = 0;
    #1;
    chk("mid_busy", md_busy, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_busy", md_busy, 0);
    chk("mid_rst_en", stage_rst, 5'b11111);
    tick();
    #2 rst_n = 1;
    tick();

    mem_req = 1;
    repeat (20) tick();
    #1;
    chk("perf_sat", perf_stall_cnt, PMAX);
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the 5-stage MIPS core; the successor to the fixed single-issue controller's hazard/stall section. Per cycle it decides operand forwarding, load-use and long-latency (mul/div) interlocks, memory-wait freezes, taken-branch flushes and debug single-stepping, and drives per-stage enable/reset vectors. It also keeps a saturating stall-cycle performance counter. It sits beside the instruction decoder and consumes decoded register-use flags from ID plus write-back tags fed back from EXE and MEM.

## Interface
- `RA_W`, 5: register address width.
- `MD_LAT`, 4: mul/div unit latency in cycles; legal range 1..255.
- `BR_FLUSH`, 1: 1 flushes IF/ID on a taken branch; 0 selects delay-slot mode with no flush.
- `CNT_W`, 16: width of the performance counter.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_rs_addr`, `id_rt_addr` in RA_W: source registers of the instruction in ID.
- `id_rs_used`, `id_rt_used` in 1: the source is actually read.
- `id_is_store` in 1: the ID instruction is a store; rt is store data.
- `id_md_start` in 1: the ID instruction issues to mul/div.
- `id_md_read` in 1: the ID instruction reads the mul/div result (HI/LO).
- `exe_wa`, `mem_wa` in RA_W: destination registers in EXE and MEM.
- `exe_wen`, `mem_wen` in 1: register write enables for EXE and MEM.
- `exe_is_load`, `mem_is_load` in 1: write-back data comes from memory.
- `mem_req` in 1: MEM stage has an access outstanding.
- `mem_ready` in 1: memory completes the access this cycle.
- `branch_taken` in 1: ID resolved a taken branch or jump.
- `debug_en` in 1: debug hold mode.
- `debug_step` in 1: asynchronous step button.
- `perf_clr` in 1: synchronous clear of the counter.
- `fwd_a`, `fwd_b` out 2: forwarding select for rs/rt, encoded NONE=0, ALU_EXE=1, ALU_MEM=2, MEM_DATA=3.
- `fwd_m` out 1: forward load data into the store-data path in MEM.
- `stage_en` out 5: per-stage enable; bit0=IF … bit4=WB.
- `stage_rst` out 5: per-stage bubble/reset.
- `md_busy` out 1: mul/div counter is non-zero.
- `stall_load`, `stall_md`, `stall_mem` out 1: cause flags.
- `perf_stall_cnt` out CNT_W: count of stall cycles.

## Operation
- **Forwarding** (combinational). Applies only when `*_used` is high and the address is non-zero.
  - An EXE match has priority over a MEM match.
  - EXE match, not a load: select ALU_EXE.
  - MEM match: select ALU_MEM, or MEM_DATA if `mem_is_load`.
- **Load-use.** An EXE load matching a used source raises `stall_load`.
  - Exception: a load matching rt when `id_is_store` gives `fwd_m`=1 and no stall.
- **Mul/div scoreboard.**
  - An accepted `id_md_start` (ID enabled, no stall) loads the counter with MD_LAT.
  - The counter decrements every cycle while non-zero, except during debug hold.
  - `id_md_start` or `id_md_read` while `md_busy` raises `stall_md`.
- **Memory wait.** `mem_req & ~mem_ready` raises `stall_mem`.
- **Debug step.**
  - `debug_step` passes through two synchroniser flops and one edge flop.
  - The rising edge produces a one-cycle step pulse.
  - While `debug_en` is high and no pulse is present, the pipeline is held.
- **Priority**, highest first; exactly one action is taken per cycle:
  1. Reset: `stage_rst`=11111, `stage_en`=11111.
  2. Debug hold: `stage_en`=00000.
  3. `stall_mem`: `stage_en`=10000 (IF..MEM frozen), `stage_rst[4]`=1 (WB bubble).
  4. `stall_load` or `stall_md`: `stage_en[1:0]`=00, `stage_rst[2]`=1 (EXE bubble).
  5. `branch_taken` with BR_FLUSH=1: `stage_rst[1]`=1.
  6. Otherwise: all enabled, no resets.
- **Cause flags** report combinational causes regardless of priority.
- **Performance counter.**
  - Increments on any stall flag when not in debug hold.
  - Saturates at all-ones.
  - `perf_clr` has priority over increment.

## Timing
- **Reset values:** md counter 0, sync/edge flops 0, `perf_stall_cnt` 0, `md_busy` 0. All outputs are valid combinationally during reset.
- Forwarding, stalls and stage controls have zero-cycle latency from their inputs.
- **Step pulse** is high in the third rising edge after `debug_step` rises, for exactly one cycle. Holding the button produces no further pulses.
- **md timing:** issue at edge N gives `md_busy` high for cycles N+1..N+MD_LAT. A reader presented at cycle N+MD_LAT+1 proceeds without a stall.
- **Simultaneous events:**
  - `stall_mem` masks a branch flush; the branch is re-presented because ID is frozen.
  - A load-use stall with `branch_taken` stalls and does not flush.
  - An md issue blocked by a stall does not load the counter.
- **Reset mid-operation:** `rst_n` low clears the md counter instantly; a pending step is lost.

## Structure
- A shared package `hazard_pkg` holds the `fwd_sel_t` enum (NONE, ALU_EXE, ALU_MEM, MEM_DATA) and the stage index constants IF=0..WB=4.
- One sub-module: `step_sync`, containing the 2-flop synchroniser and rising-edge pulse. It is reused by other debug blocks.

## Test plan
- **EXE ALU forward:** `exe_wa`=3, `exe_wen`=1, `id_rs_addr`=3, used → `fwd_a`=1, no stall. Repeat with addr 0 → `fwd_a`=0.
- **Load-use vs store:** EXE load writes r5; `id_rt_addr`=5 → `stall_load`, `stage_en`=11100, `stage_rst`=00100. Same with `id_is_store` → `fwd_m`=1 and no stall.
- **md interlock:** MD_LAT=4, issue at cycle 0; `id_md_read` from cycle 1 → stalled in cycles 1–4, proceeds in cycle 5. `perf_stall_cnt`=4.
- **Memory wait:** `mem_req`=1 with `mem_ready` low for 3 cycles plus `branch_taken` → `stage_en`=10000 and `stage_rst`=10000 for 3 cycles, then the branch flush is applied.
- **Debug step:** `debug_en`=1, one `debug_step` pulse → exactly one cycle with `stage_en`=11111, on the third edge.
- **Reset mid-md and counter saturation:** assert `rst_n` low while `md_busy` → `md_busy`=0 immediately. With CNT_W=4, 20 stall cycles → counter reads 15.
